// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Iteration counter width able to hold values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Divide-by-zero result: every quotient bit set, flag raised.
  localparam logic DBZ_Q_FILL = 1'b1;
  localparam logic DBZ_FLAG   = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider.
module div_step #(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] prem,
  input  logic             bit_in,
  input  logic [width-1:0] divisor,
  output logic [width-1:0] prem_nxt,
  output logic             q_bit
);

  logic [width:0] shifted;
  logic [width:0] diff;

  // Trial subtract at width+1 bits; the top bit is the borrow.
  always_comb begin
    shifted  = {prem, bit_in};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[width];
    prem_nxt = q_bit ? diff[width-1:0] : shifted[width-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring signed/unsigned divider with start/busy/done handshake.
// Optional feature: define DIV_ABORT_EN to add an abort input that cancels RUN.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [width-1:0] dividend,
  input  logic [width-1:0] divisor,
`ifdef DIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned      CW      = cnt_width(width);
  localparam logic [width-1:0] ONE     = width'(1);
  localparam logic [width-1:0] MIN_NEG = {1'b1, {(width-1){1'b0}}};

  div_state_t       state, state_nxt;
  logic [width-1:0] dvd_sh, dvs, prem, quo_acc;
  logic             q_neg, r_neg;
  logic [CW-1:0]    cnt;

  logic             abort_req;
  logic             is_zero, is_ovf, last_step;
  logic             load_op, load_special, step_en, finish;
  logic [width-1:0] step_rem, final_q, fix_q, fix_r;
  logic             step_q;

`ifdef DIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign is_zero   = (divisor == '0);
  assign is_ovf    = signed_op && (dividend == MIN_NEG) && (&divisor);
  assign last_step = (cnt == CW'(width - 1));

  div_step #(.width(width)) u_step (
    .prem     (prem),
    .bit_in   (dvd_sh[width-1]),
    .divisor  (dvs),
    .prem_nxt (step_rem),
    .q_bit    (step_q)
  );

  // Final-step result with sign correction applied.
  always_comb begin
    final_q = {quo_acc[width-2:0], step_q};
    fix_q   = q_neg ? (~final_q + ONE) : final_q;
    fix_r   = r_neg ? (~step_rem + ONE) : step_rem;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (is_zero || is_ovf) ? DONE : RUN;
      RUN: begin
        if (abort_req)      state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control decoded from the current state.
  always_comb begin
    load_op      = 1'b0;
    load_special = 1'b0;
    step_en      = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        load_op      = start;
        load_special = start && (is_zero || is_ovf);
      end
      RUN: begin
        step_en = !abort_req;
        finish  = !abort_req && last_step;
      end
      default: ;
    endcase
  end

  // Operand magnitudes, partial remainder, quotient accumulator and counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_sh  <= '0;
      dvs     <= '0;
      prem    <= '0;
      quo_acc <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      cnt     <= '0;
    end else if (load_op) begin
      dvd_sh  <= (signed_op && dividend[width-1]) ? (~dividend + ONE) : dividend;
      dvs     <= (signed_op && divisor[width-1])  ? (~divisor + ONE)  : divisor;
      prem    <= '0;
      quo_acc <= '0;
      q_neg   <= signed_op && (dividend[width-1] ^ divisor[width-1]);
      r_neg   <= signed_op && dividend[width-1];
      cnt     <= '0;
    end else if (step_en) begin
      dvd_sh  <= {dvd_sh[width-2:0], 1'b0};
      prem    <= step_rem;
      quo_acc <= final_q;
      cnt     <= cnt + CW'(1);
    end
  end

  // Visible outputs: handshake flags and results, updated only on entry to DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (load_special) begin
        if (is_zero) begin
          quotient    <= {width{DBZ_Q_FILL}};
          remainder   <= dividend;
          div_by_zero <= DBZ_FLAG;
        end else begin
          quotient    <= dividend;
          remainder   <= '0;
          div_by_zero <= 1'b0;
        end
      end else if (finish) begin
        quotient    <= fix_q;
        remainder   <= fix_r;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
